// File: rtl/spi_mem_responder.sv
// SPI mode-0 memory target (READ 0x03 / WRITE 0x02, 24-bit address) backed by a byte array.
// Optional FAST READ 0x0B with 8 dummy clocks is enabled by defining SPI_MEM_RESP_FAST_READ_EN.
`timescale 1ns/1ps
module spi_mem_responder #(
   parameter int DEPTH_LOG2  = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_in,
   input  logic                  reset_n_in,
   input  logic                  sclk_in,
   input  logic                  cs_n_in,
   input  logic                  mosi_in,
   output logic                  miso_out,
   output logic                  miso_oe_out,
   output logic                  access_done_out,
   input  logic [DEPTH_LOG2-1:0] dbg_addr_in,
   output logic [7:0]            dbg_data_out
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RD, WR, IGNORE} state_t;
   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic                   sclk_prev, sclk_s, cs_s, mosi_s, rise, fall;
   logic [7:0]             mem [DEPTH];
   logic [6:0]             shift_in;
   logic [7:0]             shift_out, byte_in;
   logic [4:0]             bit_cnt;
   logic [DEPTH_LOG2-1:0]  ptr, addr_nxt;
   logic                   is_write, is_fast, byte_done, miso_q, byte_last, addr_last;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign rise      = sclk_s & ~sclk_prev;
   assign fall      = ~sclk_s & sclk_prev;
   assign byte_in   = {shift_in, mosi_s};
   assign addr_nxt  = {ptr[DEPTH_LOG2-2:0], mosi_s};
   assign byte_last = rise && (bit_cnt == 5'd7);
   assign addr_last = rise && (bit_cnt == 5'd23);

   assign miso_out     = miso_q & (state == RD);
   assign miso_oe_out  = ~cs_s & ((state == RD) || (state == DUMMY));
   assign dbg_data_out = mem[dbg_addr_in];

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_in};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
         sclk_prev <= sclk_s;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) state <= IDLE;
      else             state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (cs_s) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: state_nxt = CMD;
            CMD: if (byte_last) begin
               if (byte_in == 8'h03 || byte_in == 8'h02) state_nxt = ADDR;
`ifdef SPI_MEM_RESP_FAST_READ_EN
               else if (byte_in == 8'h0B) state_nxt = ADDR;
`endif
               else state_nxt = IGNORE;
            end
            ADDR:    if (addr_last) state_nxt = is_write ? WR : (is_fast ? DUMMY : RD);
            DUMMY:   if (byte_last) state_nxt = RD;
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         shift_in        <= '0;
         shift_out       <= '0;
         bit_cnt         <= '0;
         ptr             <= '0;
         is_write        <= 1'b0;
         is_fast         <= 1'b0;
         byte_done       <= 1'b0;
         miso_q          <= 1'b0;
         access_done_out <= 1'b0;
      end else begin
         access_done_out <= 1'b0;
         if (cs_s) begin
            // Deselect drops any partial byte; report only whole bytes moved.
            if (state != IDLE) access_done_out <= byte_done;
            byte_done <= 1'b0;
            bit_cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  bit_cnt <= '0;
                  miso_q  <= 1'b0;
               end
               CMD: if (rise) begin
                  shift_in <= byte_in[6:0];
                  bit_cnt  <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd7) begin
                     bit_cnt  <= '0;
                     is_write <= (byte_in == 8'h02);
`ifdef SPI_MEM_RESP_FAST_READ_EN
                     is_fast  <= (byte_in == 8'h0B);
`else
                     is_fast  <= 1'b0;
`endif
                  end
               end
               ADDR: if (rise) begin
                  ptr     <= addr_nxt;
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd23) begin
                     bit_cnt <= '0;
                     if (!is_write && !is_fast) begin
                        shift_out <= mem[addr_nxt];
                        ptr       <= addr_nxt + DEPTH_LOG2'(1);
                     end
                  end
               end
               DUMMY: if (rise) begin
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd7) begin
                     bit_cnt   <= '0;
                     shift_out <= mem[ptr];
                     ptr       <= ptr + DEPTH_LOG2'(1);
                  end
               end
               RD: begin
                  if (fall) begin
                     miso_q    <= shift_out[7];
                     shift_out <= {shift_out[6:0], 1'b0};
                  end
                  if (rise) begin
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd7) begin
                        bit_cnt   <= '0;
                        shift_out <= mem[ptr];
                        ptr       <= ptr + DEPTH_LOG2'(1);
                        byte_done <= 1'b1;
                     end
                  end
               end
               WR: if (rise) begin
                  shift_in <= byte_in[6:0];
                  bit_cnt  <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd7) begin
                     bit_cnt   <= '0;
                     mem[ptr]  <= byte_in;
                     ptr       <= ptr + DEPTH_LOG2'(1);
                     byte_done <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_mem_responder.sv
// Self-checking bench for spi_mem_responder: bit-banged SPI master, byte-array model,
// read-data scoreboard queue; honours SPI_MEM_RESP_FAST_READ_EN for the fast-read case.
`timescale 1ns/1ps
module tb_spi_mem_responder;
   localparam int DL   = 6;
   localparam int HALF = 5;

   logic          clk_in = 1'b0, reset_n_in = 1'b0, sclk_in = 1'b0, cs_n_in = 1'b1, mosi_in = 1'b0;
   logic          miso_out, miso_oe_out, access_done_out;
   logic [DL-1:0] dbg_addr_in = '0;
   logic [7:0]    dbg_data_out;

   int   errors = 0, checks = 0, done_cnt = 0, quiet_viol = 0;
   bit   watch_quiet = 1'b0;
   logic [7:0] model [64];
   logic [7:0] exp_q [$];

   spi_mem_responder #(.DEPTH_LOG2(DL), .SYNC_STAGES(2)) dut (
      .clk_in(clk_in), .reset_n_in(reset_n_in), .sclk_in(sclk_in), .cs_n_in(cs_n_in),
      .mosi_in(mosi_in), .miso_out(miso_out), .miso_oe_out(miso_oe_out),
      .access_done_out(access_done_out), .dbg_addr_in(dbg_addr_in), .dbg_data_out(dbg_data_out)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      if (access_done_out) done_cnt++;
      if (watch_quiet && (miso_out || miso_oe_out)) quiet_viol++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic spi_bit(input logic b, output logic m, output logic oe);
      mosi_in = b;
      repeat (HALF) @(negedge clk_in);
      m  = miso_out;
      oe = miso_oe_out;
      sclk_in = 1'b1;
      repeat (HALF) @(negedge clk_in);
      sclk_in = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] b, output logic [7:0] r, output logic all_oe);
      logic m, oe;
      r = '0;
      all_oe = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(b[i], m, oe);
         r[i] = m;
         all_oe = all_oe & oe;
      end
   endtask

   task automatic sel();
      cs_n_in = 1'b0;
      repeat (HALF) @(negedge clk_in);
   endtask

   task automatic desel();
      repeat (HALF) @(negedge clk_in);
      cs_n_in = 1'b1;
      mosi_in = 1'b0;
      repeat (10) @(negedge clk_in);
   endtask

   task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
      logic [7:0] r;
      logic       oe;
      spi_byte(cmd, r, oe);
      spi_byte(addr[23:16], r, oe);
      spi_byte(addr[15:8], r, oe);
      spi_byte(addr[7:0], r, oe);
   endtask

   task automatic mem_write(input logic [23:0] addr, input logic [7:0] d0, input logic [7:0] d1);
      logic [7:0] r;
      logic       oe;
      logic [5:0] a;
      int         d;
      d = done_cnt;
      sel();
      send_hdr(8'h02, addr);
      spi_byte(d0, r, oe);
      spi_byte(d1, r, oe);
      desel();
      a = addr[5:0];
      model[a] = d0;
      a = a + 6'd1;
      model[a] = d1;
      check("wr_done_pulses", done_cnt - d, 1);
   endtask

   task automatic mem_read(input logic [23:0] addr, input int n);
      logic [7:0] r;
      logic       oe;
      logic [5:0] a;
      int         d;
      d = done_cnt;
      a = addr[5:0];
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(model[a]);
         a = a + 6'd1;
      end
      sel();
      send_hdr(8'h03, addr);
      for (int i = 0; i < n; i++) begin
         spi_byte(8'h00, r, oe);
         check("rd_oe", oe, 1);
         check("rd_data", r, exp_q.pop_front());
      end
      desel();
      check("rd_done_pulses", done_cnt - d, 1);
   endtask

   task automatic check_array(input string tag);
      for (int i = 0; i < 64; i++) begin
         dbg_addr_in = DL'(i);
         #1;
         check($sformatf("%s[%0d]", tag, i), dbg_data_out, model[i]);
      end
   endtask

   initial begin
      logic [7:0] r;
      logic       m, oe;
      int         d, q;
      for (int i = 0; i < 64; i++) model[i] = 8'h00;

      repeat (3) @(negedge clk_in);
      check("rst_miso", miso_out, 0);
      check("rst_oe", miso_oe_out, 0);
      check("rst_done", access_done_out, 0);
      reset_n_in = 1'b1;
      repeat (5) @(negedge clk_in);
      check_array("rst_arr");

      mem_write(24'h000010, 8'hA5, 8'h3C);
      dbg_addr_in = 6'h10; #1; check("wr_dbg10", dbg_data_out, 8'hA5);
      dbg_addr_in = 6'h11; #1; check("wr_dbg11", dbg_data_out, 8'h3C);
      mem_read(24'h000010, 2);

      mem_write(24'h00003F, 8'h11, 8'h22);
      dbg_addr_in = 6'h3F; #1; check("wrap_dbg3f", dbg_data_out, 8'h11);
      dbg_addr_in = 6'h00; #1; check("wrap_dbg00", dbg_data_out, 8'h22);
      mem_read(24'hFFFF3F, 2);

      d = done_cnt;
      sel();
      send_hdr(8'h02, 24'h000005);
      for (int i = 0; i < 5; i++) spi_bit(1'b1, m, oe);
      desel();
      check("abort_done_pulses", done_cnt - d, 0);
      dbg_addr_in = 6'h05; #1; check("abort_dbg05", dbg_data_out, 8'h00);
      mem_write(24'h000005, 8'h77, 8'h88);
      mem_read(24'h000004, 3);

      d = done_cnt;
      q = quiet_viol;
      watch_quiet = 1'b1;
      sel();
      spi_byte(8'h9F, r, oe);
      for (int i = 0; i < 4; i++) begin
         spi_byte(8'hFF, r, oe);
         check("unk_miso", r, 8'h00);
      end
      desel();
      watch_quiet = 1'b0;
      check("unk_quiet", quiet_viol - q, 0);
      check("unk_done_pulses", done_cnt - d, 0);
      check_array("unk_arr");

      sel();
`ifdef SPI_MEM_RESP_FAST_READ_EN
      send_hdr(8'h0B, 24'h000010);
      spi_byte(8'h00, r, oe);
      check("fr_dummy_miso", r, 8'h00);
      check("fr_dummy_oe", oe, 1);
      exp_q.push_back(model[6'h10]);
      spi_byte(8'h00, r, oe);
      check("fr_oe", oe, 1);
      check("fr_data", r, exp_q.pop_front());
      desel();
`else
      q = quiet_viol;
      watch_quiet = 1'b1;
      send_hdr(8'h0B, 24'h000010);
      spi_byte(8'h00, r, oe);
      spi_byte(8'h00, r, oe);
      check("fr_ignored_miso", r, 8'h00);
      desel();
      watch_quiet = 1'b0;
      check("fr_ignored_quiet", quiet_viol - q, 0);
`endif

      sel();
      send_hdr(8'h03, 24'h000010);
      for (int i = 0; i < 4; i++) spi_bit(1'b0, m, oe);
      #2;
      check("mid_rd_oe_before", miso_oe_out, 1);
      reset_n_in = 1'b0;
      #1;
      check("async_rst_oe", miso_oe_out, 0);
      check("async_rst_miso", miso_out, 0);
      cs_n_in = 1'b1;
      repeat (3) @(negedge clk_in);
      reset_n_in = 1'b1;
      for (int i = 0; i < 64; i++) model[i] = 8'h00;
      repeat (5) @(negedge clk_in);
      check_array("post_rst_arr");
      check("post_rst_done", access_done_out, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/spi_mem_responder.md
Name: spi_mem_responder

Overview:
- SPI mode-0 target that answers the serial-memory command set issued by the MCU's SPI memory master (READ 0x03, WRITE 0x02, 24-bit address, MSB first).
- Backed by a small on-chip byte array, so it can stand in for the PSRAM on-chip, or on the peripheral SPI bus, in self-contained builds and benches.
- All SPI pins are oversampled in the single system clock domain.

Parameters:
- DEPTH_LOG2, 6, log2 of backing array size in bytes (default 64 B); address decoded from addr[DEPTH_LOG2-1:0].
- SYNC_STAGES, 2, synchronizer flops on sclk/cs/mosi (min 2).

Ports:
- clk_in  input  1  system clock; must be >= 8x SCLK frequency.
- reset_n_in  input  1  asynchronous active-low reset.
- sclk_in  input  1  SPI clock from master, idle low.
- cs_n_in  input  1  chip select, active low.
- mosi_in  input  1  master-out data.
- miso_out  output  1  target-out data.
- miso_oe_out  output  1  high while selected and in a read data phase.
- access_done_out  output  1  1-cycle pulse on CS release after at least one complete data byte.
- dbg_addr_in  input  DEPTH_LOG2  backdoor read address.
- dbg_data_out  output  8  combinational backdoor read of array[dbg_addr_in].

Behaviour:
- Reset (async assert, sync release):
  - FSM to IDLE; miso_out=0, miso_oe_out=0, access_done_out=0.
  - Array cleared to 0x00; shift/address/bit counters cleared.
- Input conditioning:
  - sclk, cs_n and mosi each pass SYNC_STAGES flops.
  - Rise/fall events are detected from the last two synchronized sclk samples; mosi is sampled from the synchronized copy on a rise event.
  - Everything below happens at clk_in edges, on events.
- Deselect:
  - Synchronized cs_n high forces IDLE on the next clk, regardless of state; miso_oe_out=0 the same cycle.
  - A partially received byte is discarded, and no write is committed.
- States:
  - IDLE: wait for cs_n low; clear bit count; go to CMD.
  - CMD: shift 8 bits on rise events. On the 8th: 0x03 -> ADDR (read), 0x02 -> ADDR (write), anything else -> IGNORE.
  - ADDR: shift 24 bits; keep the low DEPTH_LOG2 bits as the pointer. On the 24th: read -> load shift_out with array[ptr], ptr++, go to RD; write -> go to WR.
  - RD: on each fall event, miso_out = shift_out[7] and shift left. On every 8th rise event of the phase, reload shift_out with array[ptr] and do ptr++. The first MSB is driven on the fall event following the 24th address rise. miso_oe_out=1 throughout RD.
  - WR: assemble a byte on rise events. On the 8th bit, array[ptr] <= byte, ptr++, and mark the byte complete.
  - IGNORE: miso_out=0, no state change until deselect.
- Pointer wraps modulo 2^DEPTH_LOG2 in both directions of transfer; the upper address bits are ignored.
- access_done_out asserts one cycle after the deselect is seen, only if RD or WR completed >= 1 full byte since select.
- Outside RD, miso_out holds 0.
- Backdoor port has no side effects; a dbg read racing a same-cycle write returns the old value.

Optional Feature:
- Macro SPI_MEM_RESP_FAST_READ_EN.
- Defined: command 0x0B (FAST READ) is accepted. After the 24 address bits, the FSM enters DUMMY for 8 rise events with miso_out=0 and miso_oe_out=1, then loads array[ptr] and enters RD exactly as for 0x03.
- Undefined: 0x0B goes to IGNORE like any unknown opcode.

Test Plan:
- Write then read:
  - Stimulus: select, send 0x02, addr 0x000010, bytes 0xA5 0x3C; deselect.
  - Required response: dbg[0x10]=0xA5, dbg[0x11]=0x3C; access_done_out pulses once.
  - Follow-up: select, send 0x03, addr 0x000010, clock 16 bits. MISO must return 0xA5 then 0x3C, MSB first, valid at each rising SCLK.
- Wrap-around:
  - Stimulus: write 0x11 0x22 starting at addr 0x00003F (DEPTH_LOG2=6).
  - Required response: dbg[0x3F]=0x11, dbg[0x00]=0x22. A read at 0xFFFF3F returns the same pair.
- Abort mid-byte:
  - Stimulus: 0x02, addr 0x05, 5 bits of 0xFF, then cs_n high.
  - Required response: dbg[0x05] stays 0x00; no access_done_out pulse; next transaction works normally.
- Unknown opcode:
  - Stimulus: 0x9F followed by 32 clocks.
  - Required response: miso_out=0, miso_oe_out=0 throughout; array unchanged.
- Async reset mid-read:
  - Stimulus: drop reset_n_in low during the RD phase.
  - Required response: miso_oe_out=0 immediately; array reads all 0x00 after release.
- Fast read (macro defined):
  - Stimulus: 0x0B, addr 0x10, 8 dummy clocks, then 8 clocks.
  - Required response: 0xA5 returned after the dummy byte. With the macro undefined, the same stimulus is treated as IGNORE.
